// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM macro, with a
// drain/retention sleep sequence. Read data returns two cycles after the grant.
module sram_arbiter #(
  parameter int          DATA_W  = 32,
  parameter int          ADDR_W  = 10,
  parameter logic [2:0]  EMA_VAL = 3'b010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              sram_cen_n,
  output logic              sram_wen_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q,
  output logic [2:0]        sram_ema,
  output logic              sram_retn,
  input  logic              sleep_req,
  output logic              sleep_ack
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SLEEP = 2'd2, WAKE = 2'd3} state_t;

  state_t            r_state, w_next;
  logic              r_last;        // 1: port 1 was granted most recently
  logic              r_cen_n, r_wen_n;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_d;
  logic [1:0]        r_rd_pipe;     // [0] read at macro, [1] read data on sram_q
  logic [1:0]        r_port_pipe;

  logic              w_gnt0, w_gnt1, w_any, w_we, w_inflight;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_next;
  end

  assign w_inflight = ~r_cen_n | r_rd_pipe[1];

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     if (sleep_req)   w_next = DRAIN;
      DRAIN:   if (!w_inflight) w_next = SLEEP;
      SLEEP:   if (!sleep_req)  w_next = WAKE;
      default:                  w_next = RUN;
    endcase
  end

  // sleep_req wins over pending requests, so no grant in the cycle it rises
  always_comb begin
    w_gnt0    = 1'b0;
    w_gnt1    = 1'b0;
    sram_retn = (r_state != SLEEP);
    sleep_ack = (r_state == SLEEP);
    if (r_state == RUN && !sleep_req) begin
      w_gnt0 = p0_req & (~p1_req | r_last);
      w_gnt1 = p1_req & (~p0_req | ~r_last);
    end
  end

  assign p0_gnt  = w_gnt0;
  assign p1_gnt  = w_gnt1;
  assign w_any   = w_gnt0 | w_gnt1;
  assign w_we    = w_gnt1 ? p1_we    : p0_we;
  assign w_addr  = w_gnt1 ? p1_addr  : p0_addr;
  assign w_wdata = w_gnt1 ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last      <= 1'b1;
      r_cen_n     <= 1'b1;
      r_wen_n     <= 1'b1;
      r_addr      <= '0;
      r_d         <= '0;
      r_rd_pipe   <= '0;
      r_port_pipe <= '0;
    end else begin
      r_cen_n     <= ~w_any;
      r_wen_n     <= ~(w_any & w_we);
      r_rd_pipe   <= {r_rd_pipe[0], w_any & ~w_we};
      r_port_pipe <= {r_port_pipe[0], w_gnt1};
      if (w_any) begin
        r_last <= w_gnt1;
        r_addr <= w_addr;
        r_d    <= w_wdata;
      end
    end
  end

  assign sram_cen_n = r_cen_n;
  assign sram_wen_n = r_wen_n;
  assign sram_addr  = r_addr;
  assign sram_d     = r_d;
  assign sram_ema   = EMA_VAL;

  assign p0_rvalid = r_rd_pipe[1] & ~r_port_pipe[1];
  assign p1_rvalid = r_rd_pipe[1] &  r_port_pipe[1];
  assign p0_rdata  = p0_rvalid ? sram_q : '0;
  assign p1_rdata  = p1_rvalid ? sram_q : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM macro, per-cycle reference model of
// grants, macro pins and read returns, directed scenarios then random traffic.
module tb_sram_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0, rst = 1'b0;
  logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, sleep_req = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          sram_cen_n, sram_wen_n, sram_retn, sleep_ack;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;
  logic [2:0]    sram_ema;

  always #5 clk = ~clk;

  sram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .EMA_VAL(3'b010)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sram_cen_n(sram_cen_n), .sram_wen_n(sram_wen_n), .sram_addr(sram_addr),
    .sram_d(sram_d), .sram_q(sram_q), .sram_ema(sram_ema), .sram_retn(sram_retn),
    .sleep_req(sleep_req), .sleep_ack(sleep_ack)
  );

  // Behavioural single-port macro: output registered on the access edge.
  logic [DW-1:0] smem [1<<AW];
  always @(posedge clk)
    if (!sram_cen_n) begin
      if (!sram_wen_n) smem[sram_addr] <= sram_d;
      else             sram_q <= smem[sram_addr];
    end

  // Reference model state
  typedef struct { int due; bit port; logic [DW-1:0] data; } rd_t;
  rd_t           pend[$];
  logic [DW-1:0] mmem [1<<AW];
  int            vecs = 0, errs = 0, cyc = 0;
  bit            last = 1'b1, pg = 1'b0, pwe = 1'b0;
  int            mode = 0;  // 0 run, 1 drain, 2 sleep, 3 wake
  logic [AW-1:0] haddr = '0;
  logic [DW-1:0] hd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    last = 1'b1; pg = 1'b0; pwe = 1'b0; mode = 0; haddr = '0; hd = '0;
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, advances model.
  task automatic cycle();
    bit g0, g1, ev0, ev1, infl, port, we;
    logic [DW-1:0] ed0, ed1, wd;
    logic [AW-1:0] a;
    g0 = 0; g1 = 0; ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
    #3;
    if (mode == 0 && !sleep_req) begin
      if (p0_req && p1_req) begin
        if (last) g0 = 1; else g1 = 1;
      end else begin
        g0 = p0_req; g1 = p1_req;
      end
    end
    infl = pg || (pend.size() != 0);
    if (pend.size() != 0 && pend[0].due == cyc) begin
      if (pend[0].port) begin ev1 = 1; ed1 = pend[0].data; end
      else              begin ev0 = 1; ed0 = pend[0].data; end
      void'(pend.pop_front());
    end
    chk("p0_gnt", 64'(p0_gnt), 64'(g0));
    chk("p1_gnt", 64'(p1_gnt), 64'(g1));
    chk("p0_rvalid", 64'(p0_rvalid), 64'(ev0));
    chk("p1_rvalid", 64'(p1_rvalid), 64'(ev1));
    chk("p0_rdata", 64'(p0_rdata), 64'(ed0));
    chk("p1_rdata", 64'(p1_rdata), 64'(ed1));
    chk("cen_n", 64'(sram_cen_n), 64'(!pg));
    chk("wen_n", 64'(sram_wen_n), 64'(pg ? !pwe : 1'b1));
    chk("addr", 64'(sram_addr), 64'(haddr));
    chk("d", 64'(sram_d), 64'(hd));
    chk("retn", 64'(sram_retn), 64'(mode != 2));
    chk("ack", 64'(sleep_ack), 64'(mode == 2));
    chk("ema", 64'(sram_ema), 64'(3'b010));
    if (g0 || g1) begin
      port = g1;
      we = port ? p1_we : p0_we;
      a  = port ? p1_addr : p0_addr;
      wd = port ? p1_wdata : p0_wdata;
      last = port;
      if (we) mmem[a] = wd;
      else    pend.push_back('{cyc + 2, port, mmem[a]});
      haddr = a; hd = wd; pg = 1; pwe = we;
    end else pg = 0;
    case (mode)
      0: if (sleep_req) mode = 1;
      1: if (!infl) mode = 2;
      2: if (!sleep_req) mode = 3;
      default: mode = 0;
    endcase
    @(posedge clk); #1;
    cyc++;
    if (g0) p0_req = 0;
    if (g1) p1_req = 0;
  endtask

  // Holds rst low for one edge, checking reset values, then releases it.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_gnt", 64'({p0_gnt, p1_gnt}), 64'(0));
    chk("rst_rvalid", 64'({p0_rvalid, p1_rvalid}), 64'(0));
    chk("rst_rdata", 64'(p0_rdata | p1_rdata), 64'(0));
    chk("rst_cen_wen", 64'({sram_cen_n, sram_wen_n}), 64'(2'b11));
    chk("rst_addr_d", 64'({sram_addr, sram_d}), 64'(0));
    chk("rst_retn_ack", 64'({sram_retn, sleep_ack}), 64'(2'b10));
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
    cyc++;
  endtask

  task automatic rd(input bit p, input logic [AW-1:0] a);
    if (p) begin p1_req = 1; p1_we = 0; p1_addr = a; end
    else   begin p0_req = 1; p0_we = 0; p0_addr = a; end
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin smem[i] = '0; mmem[i] = '0; end
    @(posedge clk); #1;
    do_reset();

    // write then read back the same word across ports
    p0_req = 1; p0_we = 1; p0_addr = 10'h005; p0_wdata = 32'hDEADBEEF;
    cycle();
    rd(1, 10'h005);
    repeat (4) cycle();

    // continuous contention on reads: strict alternation
    for (int i = 0; i < 6; i++) begin
      if (!p0_req) rd(0, AW'($urandom_range(0, 15)));
      if (!p1_req) rd(1, AW'($urandom_range(0, 15)));
      cycle();
    end
    p0_req = 0; p1_req = 0;
    repeat (3) cycle();

    // single requester streaming reads, no bubbles
    for (int i = 0; i < 4; i++) begin
      rd(1, AW'(i + 4));
      cycle();
    end
    repeat (3) cycle();

    // sleep raised together with a request
    rd(0, 10'h005);
    sleep_req = 1;
    repeat (5) cycle();
    sleep_req = 0;
    repeat (4) cycle();

    // reset during an in-flight read
    rd(1, 10'h005);
    cycle();
    do_reset();
    repeat (4) cycle();

    // random traffic with occasional sleep episodes
    for (int i = 0; i < 400; i++) begin
      if (!p0_req && $urandom_range(0, 2) != 0) begin
        p0_req = 1; p0_we = 1'($urandom_range(0, 1));
        p0_addr = AW'($urandom_range(0, 15)); p0_wdata = $urandom;
      end
      if (!p1_req && $urandom_range(0, 2) != 0) begin
        p1_req = 1; p1_we = 1'($urandom_range(0, 1));
        p1_addr = AW'($urandom_range(0, 15)); p1_wdata = $urandom;
      end
      sleep_req = ($urandom_range(0, 39) == 0) || (sleep_req && $urandom_range(0, 3) != 0);
      cycle();
    end
    sleep_req = 0;
    repeat (8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
